apb_master_bridge: RTL and testbench
====================================

Name: apb_master_bridge

Overview:
- Upstream APB requester that drives the apb_slave register block.
- Converts a simple valid/ready command channel (one read or write per command) into a compliant APB SETUP/ACCESS sequence.
- Waits for PREADY, then returns read data and status on a valid/ready response channel.
- Replaces bench-driven APB tasks as the single APB master in the subsystem.

Parameters:
- ADDR_W, 4, width of cmd_addr and PADDR.
- DATA_W, 32, width of all data paths.
- TIMEOUT_CYCLES, 16, maximum ACCESS-phase wait states before abort. Used only with the optional feature; legal range 1..255.

Ports:
- PCLK  in  1  clock; all logic on the rising edge.
- PRESET  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  bridge accepts a command this cycle.
- cmd_write  in  1  1=write, 0=read.
- cmd_addr  in  ADDR_W  target address.
- cmd_wdata  in  DATA_W  write data.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  consumer accepts the response.
- rsp_rdata  out  DATA_W  read data; 0 for writes.
- rsp_err  out  1  transfer aborted by timeout.
- PADDR  out  ADDR_W  APB address.
- PWDATA  out  DATA_W  APB write data.
- PWRITE  out  1  APB direction.
- PSEL  out  1  APB select.
- PENABLE  out  1  APB enable.
- PRDATA  in  DATA_W  APB read data.
- PREADY  in  1  APB slave ready.

Behaviour:
- One clock (PCLK); reset is synchronous and active-high (PRESET sampled on the rising edge of PCLK). All outputs are registered.
- Reset values: state=IDLE, cmd_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, PADDR=0, PWDATA=0, PWRITE=0, PSEL=0, PENABLE=0.
- Reset asserted mid-transfer: all outputs return to reset values on the next edge. The in-flight command is dropped and no response is produced.
- FSM states: IDLE, SETUP, ACCESS, RESP.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid: latch cmd_write, cmd_addr and cmd_wdata into PWRITE/PADDR/PWDATA; go to SETUP; cmd_ready=0.
- SETUP (exactly one cycle): PSEL=1, PENABLE=0; go to ACCESS.
- ACCESS:
  - PSEL=1, PENABLE=1.
  - PREADY=0: stay in ACCESS (wait state).
  - PREADY=1:
    - Read: capture PRDATA into rsp_rdata. Write: rsp_rdata=0.
    - rsp_err=0; PSEL=0, PENABLE=0; go to RESP.
- RESP:
  - rsp_valid=1; cmd_ready stays 0.
  - On rsp_ready: rsp_valid=0, cmd_ready=1, go to IDLE.
  - A rsp_ready that is already high when rsp_valid rises completes the handshake in that first RESP cycle.
- PADDR, PWRITE and PWDATA are stable from SETUP through ACCESS completion and hold their values until the next accept. The bridge never changes them while PSEL=1.
- PENABLE is never 1 while PSEL=0. PSEL never stays high across two transfers: there is at least one idle cycle (RESP) between transfers.
- Latency with zero wait states, command accepted at edge 0:
  - SETUP occupies cycle 1.
  - ACCESS occupies cycle 2; PREADY is sampled at the end of cycle 2.
  - rsp_valid is high in cycle 3.
  - Throughput is at best 1 transfer per 4 cycles.
- Each wait state adds exactly 1 cycle.
- Commands presented while cmd_ready=0 are ignored and must be held by the requester.
- rsp_rdata and rsp_err are stable while rsp_valid=1 and rsp_ready=0.

Optional Feature:
- Macro: APB_MASTER_TIMEOUT_EN.
- Defined:
  - A wait counter is cleared on entry to ACCESS and increments on each ACCESS cycle with PREADY=0.
  - When the counter reaches TIMEOUT_CYCLES with PREADY still 0, the transfer is aborted: PSEL=0, PENABLE=0, rsp_rdata=0, rsp_err=1; go to RESP.
  - PREADY=1 in the same cycle the limit is reached wins: normal completion, rsp_err=0.
- Undefined: no counter; ACCESS waits indefinitely and rsp_err is tied to 0.

Test Plan:
- Reset, then write 0x0=CAFEBABE with PREADY=1 -> PSEL=1/PENABLE=0 one cycle after accept, PENABLE=1 the next cycle; PADDR=0x0, PWDATA=CAFEBABE, PWRITE=1 stable; rsp_valid in cycle 3; rsp_rdata=0, rsp_err=0.
- Writes to 0x4=FACECAFE and 0x8=12345678, then reads of 0x0/0x4/0x8 with the slave returning the stored values -> rsp_rdata = CAFEBABE, FACECAFE, 12345678; PWRITE=0 during the reads.
- Read 0x4 with PREADY low for 3 ACCESS cycles -> PSEL/PENABLE held 4 ACCESS cycles, rsp_valid in cycle 6, PRDATA captured only in the PREADY=1 cycle.
- Hold rsp_ready=0 for 5 cycles after a response -> rsp_valid and data stable, cmd_ready=0, no new PSEL even with cmd_valid=1; on rsp_ready=1, return to IDLE and accept the pending command next.
- Assert PRESET during ACCESS of a write to 0x8 -> next edge: PSEL=0, PENABLE=0, rsp_valid=0, cmd_ready=1, no response issued.
- With APB_MASTER_TIMEOUT_EN and TIMEOUT_CYCLES=16, hold PREADY=0 -> abort after 16 wait cycles with rsp_err=1, rsp_rdata=0. Repeat with PREADY=1 on the 16th cycle -> normal completion, rsp_err=0.

Source files
------------

// File: rtl/apb_master_bridge.sv
// apb_master_bridge: turns a valid/ready command into one APB SETUP/ACCESS transfer and returns a valid/ready response
//   PCLK, PRESET                  clock, synchronous active-high reset
//   cmd_valid/ready/write/addr/wdata  command channel, one read or write per command
//   rsp_valid/ready/rdata/err         response channel; rdata is 0 for writes, err flags a timeout abort
//   PADDR/PWDATA/PWRITE/PSEL/PENABLE  APB requester outputs, PRDATA/PREADY APB completer inputs
//   APB_MASTER_TIMEOUT_EN             when defined, aborts ACCESS after TIMEOUT_CYCLES wait states
module apb_master_bridge #(
    parameter int ADDR_W         = 4,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic              PCLK,
    input  logic              PRESET,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic [ADDR_W-1:0] PADDR,
    output logic [DATA_W-1:0] PWDATA,
    output logic              PWRITE,
    output logic              PSEL,
    output logic              PENABLE,
    input  logic [DATA_W-1:0] PRDATA,
    input  logic              PREADY
);
    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be within 1..255");
    end

    state_t            state_q, state_d;
    logic              cmd_ready_q, cmd_ready_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
    logic [ADDR_W-1:0] paddr_q, paddr_d;
    logic [DATA_W-1:0] pwdata_q, pwdata_d;
    logic              pwrite_q, pwrite_d;
    logic              psel_q, psel_d;
    logic              penable_q, penable_d;
`ifdef APB_MASTER_TIMEOUT_EN
    localparam logic [7:0] WAIT_LIMIT = 8'(TIMEOUT_CYCLES - 1);
    logic [7:0] wait_q, wait_d;
    logic       rsp_err_q, rsp_err_d;
    // wait_q counts the PREADY=0 ACCESS cycles already seen, so a limit hit means this is the last allowed one
    logic       timeout;
    assign timeout = !PREADY && wait_q == WAIT_LIMIT;
    assign rsp_err = rsp_err_q;
`else
    assign rsp_err = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        cmd_ready_d = cmd_ready_q;
        rsp_valid_d = rsp_valid_q;
        rsp_rdata_d = rsp_rdata_q;
        paddr_d     = paddr_q;
        pwdata_d    = pwdata_q;
        pwrite_d    = pwrite_q;
        psel_d      = psel_q;
        penable_d   = penable_q;
`ifdef APB_MASTER_TIMEOUT_EN
        rsp_err_d   = rsp_err_q;
        wait_d      = (state_q == ACCESS && !PREADY) ? wait_q + 8'd1 : 8'd0;
`endif
        case (state_q)
            IDLE: if (cmd_valid) begin
                state_d     = SETUP;
                cmd_ready_d = 1'b0;
                paddr_d     = cmd_addr;
                pwdata_d    = cmd_wdata;
                pwrite_d    = cmd_write;
                psel_d      = 1'b1;
            end
            SETUP: begin
                state_d   = ACCESS;
                penable_d = 1'b1;
            end
            ACCESS: if (PREADY) begin
                state_d     = RESP;
                rsp_valid_d = 1'b1;
                rsp_rdata_d = pwrite_q ? '0 : PRDATA;
                psel_d      = 1'b0;
                penable_d   = 1'b0;
`ifdef APB_MASTER_TIMEOUT_EN
                rsp_err_d   = 1'b0;
            end else if (timeout) begin
                state_d     = RESP;
                rsp_valid_d = 1'b1;
                rsp_rdata_d = '0;
                rsp_err_d   = 1'b1;
                psel_d      = 1'b0;
                penable_d   = 1'b0;
`endif
            end
            RESP: if (rsp_ready) begin
                state_d     = IDLE;
                rsp_valid_d = 1'b0;
                cmd_ready_d = 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state_q     <= IDLE;
            cmd_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            paddr_q     <= '0;
            pwdata_q    <= '0;
            pwrite_q    <= 1'b0;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
`ifdef APB_MASTER_TIMEOUT_EN
            rsp_err_q   <= 1'b0;
            wait_q      <= 8'd0;
`endif
        end else begin
            state_q     <= state_d;
            cmd_ready_q <= cmd_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            paddr_q     <= paddr_d;
            pwdata_q    <= pwdata_d;
            pwrite_q    <= pwrite_d;
            psel_q      <= psel_d;
            penable_q   <= penable_d;
`ifdef APB_MASTER_TIMEOUT_EN
            rsp_err_q   <= rsp_err_d;
            wait_q      <= wait_d;
`endif
        end
    end

    assign cmd_ready = cmd_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign PADDR     = paddr_q;
    assign PWDATA    = pwdata_q;
    assign PWRITE    = pwrite_q;
    assign PSEL      = psel_q;
    assign PENABLE   = penable_q;
endmodule

// File: tb/tb_apb_master_bridge.sv
// tb_apb_master_bridge: self-checking bench for apb_master_bridge with a small APB completer memory
module tb_apb_master_bridge;
    logic        PCLK = 1'b0;
    logic        PRESET = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_write = 1'b0;
    logic [3:0]  cmd_addr = '0;
    logic [31:0] cmd_wdata = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b1;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic [3:0]  PADDR;
    logic [31:0] PWDATA;
    logic        PWRITE;
    logic        PSEL;
    logic        PENABLE;
    logic [31:0] PRDATA;
    logic        PREADY = 1'b0;

    apb_master_bridge dut (
        .PCLK(PCLK), .PRESET(PRESET),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .PADDR(PADDR), .PWDATA(PWDATA), .PWRITE(PWRITE), .PSEL(PSEL), .PENABLE(PENABLE),
        .PRDATA(PRDATA), .PREADY(PREADY)
    );

    always #5 PCLK = ~PCLK;

    typedef struct {
        logic        wr;
        logic [3:0]  addr;
        logic [31:0] wdata;
        int          waits;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    int          n_cmp = 0;
    int          n_bad = 0;
    int          cyc = 0;
    int          t0 = 0;
    logic [32:0] exp_q[$];
    logic [32:0] cur = '0;
    bit          seen = 1'b0;
    logic [31:0] mem[16];

    // completer: drives data only in the PREADY cycle, garbage otherwise
    assign PRDATA = PREADY ? mem[PADDR] : 32'hDEAD_BEEF;
    always @(posedge PCLK) begin
        cyc++;
        if (PSEL && PENABLE && PREADY && PWRITE) mem[PADDR] <= PWDATA;
    end

    task automatic chk(input string name, input logic [32:0] act, input logic [32:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // response scoreboard: pops on the first response cycle, then checks it holds while stalled
    always @(negedge PCLK) begin
        if (rsp_valid && !seen) begin
            if (exp_q.size() == 0) chk("unexpected_rsp", 33'd1, 33'd0);
            else begin
                cur = exp_q.pop_front();
                chk("rsp_rdata", {1'b0, rsp_rdata}, {1'b0, cur[31:0]});
                chk("rsp_err", {32'd0, rsp_err}, {32'd0, cur[32]});
            end
        end else if (rsp_valid) begin
            chk("rsp_rdata_hold", {1'b0, rsp_rdata}, {1'b0, cur[31:0]});
            chk("rsp_err_hold", {32'd0, rsp_err}, {32'd0, cur[32]});
        end
        seen = rsp_valid;
    end

    task automatic issue(input vec_t v, input bit expect_rsp);
        int n = 0;
        cmd_valid = 1'b1;
        cmd_write = v.wr;
        cmd_addr  = v.addr;
        cmd_wdata = v.wdata;
        while (!cmd_ready && n < 20) begin
            @(negedge PCLK);
            n++;
        end
        chk("accept_bound", {32'd0, n < 20}, 33'd1);
        if (expect_rsp) exp_q.push_back({v.exp_err, v.exp_rdata});
        t0 = cyc;
        @(negedge PCLK);
        cmd_valid = 1'b0;
        chk("setup_psel", {31'd0, PSEL, PENABLE}, 33'b10);
        chk("setup_cmd_ready", {32'd0, cmd_ready}, 33'd0);
        chk("setup_paddr", {29'd0, PADDR}, {29'd0, v.addr});
        chk("setup_pwrite", {32'd0, PWRITE}, {32'd0, v.wr});
        chk("setup_pwdata", {1'b0, PWDATA}, {1'b0, v.wdata});
    endtask

    task automatic access(input vec_t v);
        @(negedge PCLK);
        for (int w = 0; w <= v.waits; w++) begin
            chk("access_psel", {31'd0, PSEL, PENABLE}, 33'b11);
            chk("access_addr", {28'd0, PWRITE, PADDR}, {28'd0, v.wr, v.addr});
            chk("access_pwdata", {1'b0, PWDATA}, {1'b0, v.wdata});
            PREADY = (w == v.waits);
            @(negedge PCLK);
        end
        PREADY = 1'b0;
        chk("rsp_latency", 33'(cyc - t0), 33'(3 + v.waits));
        chk("rsp_valid", {30'd0, rsp_valid, PSEL, PENABLE}, 33'b100);
    endtask

    task automatic back_to_idle();
        @(negedge PCLK);
        chk("idle_after_rsp", {31'd0, rsp_valid, cmd_ready}, 33'b01);
    endtask

    vec_t tbl[9];
    vec_t v;

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = '0;
        tbl[0] = '{1'b1, 4'h0, 32'hCAFE_BABE, 0, 32'h0, 1'b0};
        tbl[1] = '{1'b1, 4'h4, 32'hFACE_CAFE, 0, 32'h0, 1'b0};
        tbl[2] = '{1'b1, 4'h8, 32'h1234_5678, 0, 32'h0, 1'b0};
        tbl[3] = '{1'b0, 4'h0, 32'h0, 0, 32'hCAFE_BABE, 1'b0};
        tbl[4] = '{1'b0, 4'h4, 32'h0, 0, 32'hFACE_CAFE, 1'b0};
        tbl[5] = '{1'b0, 4'h8, 32'h0, 0, 32'h1234_5678, 1'b0};
        tbl[6] = '{1'b0, 4'h4, 32'h0, 3, 32'hFACE_CAFE, 1'b0};
        tbl[7] = '{1'b1, 4'h4, 32'h0BAD_F00D, 1, 32'h0, 1'b0};
        tbl[8] = '{1'b0, 4'h4, 32'h0, 2, 32'h0BAD_F00D, 1'b0};

        repeat (3) @(negedge PCLK);
        PRESET = 1'b0;
        chk("reset_ctrl", {29'd0, cmd_ready, rsp_valid, PSEL, PENABLE}, 33'b1000);
        chk("reset_rsp", {rsp_err, rsp_rdata}, 33'd0);
        chk("reset_apb", {PWRITE, PADDR, PWDATA[27:0]}, 33'd0);

        for (int i = 0; i < 9; i++) begin
            issue(tbl[i], 1'b1);
            access(tbl[i]);
            back_to_idle();
        end

        // stalled response with a command waiting behind it
        rsp_ready = 1'b0;
        v = '{1'b0, 4'h8, 32'h0, 0, 32'h1234_5678, 1'b0};
        issue(v, 1'b1);
        access(v);
        cmd_valid = 1'b1;
        cmd_write = 1'b1;
        cmd_addr  = 4'hC;
        cmd_wdata = 32'h55AA_55AA;
        for (int i = 0; i < 5; i++) begin
            @(negedge PCLK);
            chk("stall_hold", {30'd0, rsp_valid, cmd_ready, PSEL}, 33'b100);
        end
        rsp_ready = 1'b1;
        back_to_idle();
        v = '{1'b1, 4'hC, 32'h55AA_55AA, 0, 32'h0, 1'b0};
        issue(v, 1'b1);
        access(v);
        back_to_idle();

`ifdef APB_MASTER_TIMEOUT_EN
        v = '{1'b0, 4'hC, 32'h0, 0, 32'h0, 1'b1};
        issue(v, 1'b1);
        @(negedge PCLK);
        for (int i = 0; i < 16; i++) begin
            chk("to_access", {31'd0, PSEL, PENABLE}, 33'b11);
            @(negedge PCLK);
        end
        chk("to_latency", 33'(cyc - t0), 33'd18);
        chk("to_rsp", {30'd0, rsp_valid, PSEL, PENABLE}, 33'b100);
        back_to_idle();
        v = '{1'b0, 4'hC, 32'h0, 15, 32'h55AA_55AA, 1'b0};
        issue(v, 1'b1);
        access(v);
        back_to_idle();
`endif

        // reset in the middle of ACCESS drops the transfer
        v = '{1'b1, 4'h8, 32'hFFFF_0000, 0, 32'h0, 1'b0};
        issue(v, 1'b0);
        @(negedge PCLK);
        chk("rst_pre_access", {31'd0, PSEL, PENABLE}, 33'b11);
        PRESET = 1'b1;
        @(negedge PCLK);
        PRESET = 1'b0;
        chk("rst_mid_ctrl", {29'd0, cmd_ready, rsp_valid, PSEL, PENABLE}, 33'b1000);
        chk("rst_mid_apb", {1'b0, PWDATA}, 33'd0);
        repeat (4) @(negedge PCLK);
        chk("rst_no_rsp", {32'd0, rsp_valid}, 33'd0);
        v = '{1'b0, 4'h8, 32'h0, 0, 32'h1234_5678, 1'b0};
        issue(v, 1'b1);
        access(v);
        back_to_idle();

        chk("queue_empty", 33'(exp_q.size()), 33'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end
endmodule
